// File: rtl/blip_sched.sv
// Round-robin blip scheduler: arbitrates per-channel note-on requests into a small
// FIFO and plays each as a delayed, fixed-length pulse on one 4-bit output.
module blip_sched #(
  parameter int         NUM_CH     = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter int         DELAY_CYC  = 1,
  parameter int         HIGH_CYC   = 4096,
  parameter int         GAP_CYC    = 4096,
  parameter logic [3:0] LEVEL      = 4'd12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*7-1:0]   req_note,
  output logic [NUM_CH-1:0]     ack,
  output logic [3:0]            blip_out,
  output logic                  busy,
  output logic [2:0]            cur_ch,
  output logic [6:0]            cur_note
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Zero-length phases are stretched to one cycle so the sequencer never stalls.
  localparam int D_EFF = (DELAY_CYC < 1) ? 1 : DELAY_CYC;
  localparam int H_EFF = (HIGH_CYC < 1) ? 1 : HIGH_CYC;
  localparam int G_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam logic [19:0] DELAY_LD = 20'(D_EFF - 1);
  localparam logic [19:0] HIGH_LD  = 20'(H_EFF - 1);
  localparam logic [19:0] GAP_LD   = 20'(G_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_HIGH  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [19:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]     ack_q, ack_d;
  logic [3:0]            blip_q, blip_d;
  logic [2:0]            cur_ch_q, cur_ch_d;
  logic [6:0]            cur_note_q, cur_note_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [9:0]            mem_q [FIFO_DEPTH];

  logic [6:0]            note_arr [8];
  logic [7:0]            req_ok_pad;
  logic [7:0]            grant_onehot;
  logic [3:0]            cand_idx;
  logic                  grant_found;
  logic [2:0]            grant_idx;
  logic                  push;
  logic                  pop;
  logic                  fifo_nempty;
  logic [9:0]            head_entry;
  logic [2:0]            head_ch;
  logic [6:0]            head_note;

  // Padded to eight lanes so a 3-bit channel index always selects in range.
  for (genvar gi = 0; gi < 8; gi++) begin : g_note
    if (gi < NUM_CH) begin : g_real
      assign note_arr[gi] = req_note[7*gi +: 7];
    end else begin : g_pad
      assign note_arr[gi] = 7'd0;
    end
  end

  // A channel acked last cycle may still be asserting req; it is masked here.
  always_comb begin
    req_ok_pad  = 8'(req & ~ack_q);
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand_idx    = 4'd0;
    if (en && (count_q < FULL_CNT)) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand_idx = {1'b0, ptr_q} + 4'(k);
        if (cand_idx >= 4'(NUM_CH)) begin
          cand_idx = cand_idx - 4'(NUM_CH);
        end
        if (!grant_found && req_ok_pad[cand_idx[2:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx[2:0];
        end
      end
    end
  end

  always_comb begin
    grant_onehot = 8'd1 << grant_idx;
    push         = grant_found;
    ack_d        = grant_found ? grant_onehot[NUM_CH-1:0] : '0;
    ptr_d        = grant_found ? grant_idx : ptr_q;
  end

  assign fifo_nempty = (count_q != '0);
  assign head_entry  = mem_q[rd_ptr_q];
  assign head_ch     = head_entry[9:7];
  assign head_note   = head_entry[6:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {grant_idx, note_arr[grant_idx]};
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Sequencer; everything holds while en is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_ch_d   = cur_ch_q;
    cur_note_d = cur_note_q;
    pop        = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (fifo_nempty) begin
            pop        = 1'b1;
            cur_ch_d   = head_ch;
            cur_note_d = head_note;
            cnt_d      = DELAY_LD;
            state_d    = S_DELAY;
          end
        end
        S_DELAY, S_HIGH: begin
          if (fifo_nempty && (head_ch == cur_ch_q)) begin
            // Same channel struck again before its pulse finished: restart it.
            pop        = 1'b1;
            cur_note_d = head_note;
            cnt_d      = DELAY_LD;
            state_d    = S_DELAY;
          end else if (cnt_q == 20'd0) begin
            if (state_q == S_DELAY) begin
              cnt_d   = HIGH_LD;
              state_d = S_HIGH;
            end else begin
              cnt_d   = GAP_LD;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == 20'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output level follows the next state, so it returns to LEVEL as soon as en resumes.
  assign blip_d = (en && (state_d == S_HIGH)) ? LEVEL : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 20'd0;
      ack_q      <= '0;
      blip_q     <= 4'd0;
      cur_ch_q   <= 3'd0;
      cur_note_q <= 7'd0;
      ptr_q      <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      blip_q     <= blip_d;
      cur_ch_q   <= cur_ch_d;
      cur_note_q <= cur_note_d;
      ptr_q      <= ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign ack      = ack_q;
  assign blip_out = blip_q;
  assign cur_ch   = cur_ch_q;
  assign cur_note = cur_note_q;
  assign busy     = (state_q != S_IDLE) || fifo_nempty;

endmodule
